// File: rtl/planificador_cubos_if.sv
// rtl/planificador_cubos_if.sv - spawn scheduler signal bundle
// master: the scheduler; slave: game control and cube-slot datapath side.
interface planificador_cubos_if #(
    parameter int NUM_CUBOS = 4
) ();
    localparam int IDX_W = (NUM_CUBOS > 1) ? $clog2(NUM_CUBOS) : 1;

    logic                 habilitar_cubos;
    logic                 tick_frame;
    logic [NUM_CUBOS-1:0] cubo_activo;
    logic                 lanzar;
    logic [IDX_W-1:0]     lanzar_idx;
    logic [2:0]           lanzar_columna;
    logic [3:0]           nivel;
    logic [7:0]           total_lanzados;
    logic                 todos_ocupados;

    modport master (
        input  habilitar_cubos,
        input  tick_frame,
        input  cubo_activo,
        output lanzar,
        output lanzar_idx,
        output lanzar_columna,
        output nivel,
        output total_lanzados,
        output todos_ocupados
    );

    modport slave (
        output habilitar_cubos,
        output tick_frame,
        output cubo_activo,
        input  lanzar,
        input  lanzar_idx,
        input  lanzar_columna,
        input  nivel,
        input  total_lanzados,
        input  todos_ocupados
    );
endinterface

// File: rtl/planificador_cubos.sv
// rtl/planificador_cubos.sv - cube spawn scheduler
// Counts frame ticks, grabs the lowest free slot, picks a column, speeds up per level.
module planificador_cubos #(
    parameter int         NUM_CUBOS         = 4,
    parameter int         NUM_COLUMNAS      = 8,
    parameter int         INTERVALO_INICIAL = 60,
    parameter int         INTERVALO_MIN     = 15,
    parameter int         DECREMENTO        = 5,
    parameter int         LANZ_POR_NIVEL    = 8,
    parameter logic [7:0] SEMILLA           = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    planificador_cubos_if.master  bus
);
    localparam int IDX_W = (NUM_CUBOS > 1) ? $clog2(NUM_CUBOS) : 1;
    localparam int COL_W = $clog2(NUM_COLUMNAS);
    localparam logic [7:0] INTERVALO_INI = 8'(INTERVALO_INICIAL);
    localparam logic [7:0] ULTIMO_NIVEL  = 8'(LANZ_POR_NIVEL - 1);
    localparam logic [8:0] UMBRAL        = 9'(INTERVALO_MIN + DECREMENTO);

    typedef enum logic [1:0] {
        E_REPOSO = 2'd0,
        E_CUENTA = 2'd1,
        E_ELEGIR = 2'd2,
        E_LANZAR = 2'd3
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [7:0]       contador_q, contador_d;
    logic [7:0]       intervalo_q, intervalo_d;
    logic [7:0]       cuenta_nivel_q, cuenta_nivel_d;
    logic [COL_W-1:0] columna_prev_q, columna_prev_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             lanzar_q, lanzar_d;
    logic [IDX_W-1:0] lanzar_idx_q, lanzar_idx_d;
    logic [COL_W-1:0] lanzar_columna_q, lanzar_columna_d;
    logic [3:0]       nivel_q, nivel_d;
    logic [7:0]       total_q, total_d;
    logic             todos_q, todos_d;

    logic             libre_hay;
    logic [IDX_W-1:0] libre_idx;
    logic [COL_W-1:0] col_cand;
    logic [COL_W-1:0] col_elegida;
    logic [7:0]       intervalo_reducido;

    always_comb begin
        libre_hay = 1'b0;
        libre_idx = '0;
        // Scan downward so the lowest free index is the one left standing.
        for (int i = NUM_CUBOS - 1; i >= 0; i--) begin
            if (!bus.cubo_activo[i]) begin
                libre_hay = 1'b1;
                libre_idx = IDX_W'(i);
            end
        end

        col_cand    = lfsr_q[COL_W-1:0];
        col_elegida = (col_cand == columna_prev_q) ? col_cand + 1'b1 : col_cand;

        intervalo_reducido = ({1'b0, intervalo_q} >= UMBRAL)
                           ? intervalo_q - 8'(DECREMENTO)
                           : 8'(INTERVALO_MIN);
    end

    always_comb begin
        estado_d         = estado_q;
        contador_d       = contador_q;
        intervalo_d      = intervalo_q;
        cuenta_nivel_d   = cuenta_nivel_q;
        columna_prev_d   = columna_prev_q;
        lfsr_d           = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lanzar_d         = 1'b0;
        lanzar_idx_d     = lanzar_idx_q;
        lanzar_columna_d = lanzar_columna_q;
        nivel_d          = nivel_q;
        total_d          = total_q;
        todos_d          = 1'b0;

        case (estado_q)
            E_REPOSO: begin
                if (bus.habilitar_cubos) begin
                    estado_d       = E_CUENTA;
                    contador_d     = INTERVALO_INI;
                    intervalo_d    = INTERVALO_INI;
                    nivel_d        = 4'd0;
                    total_d        = 8'd0;
                    cuenta_nivel_d = 8'd0;
                end
            end
            E_CUENTA: begin
                if (!bus.habilitar_cubos) begin
                    estado_d = E_REPOSO;
                end else if (bus.tick_frame) begin
                    contador_d = contador_q - 8'd1;
                    if (contador_q == 8'd1) begin
                        estado_d = E_ELEGIR;
                    end
                end
            end
            E_ELEGIR: begin
                if (!bus.habilitar_cubos) begin
                    estado_d = E_REPOSO;
                end else if (libre_hay) begin
                    estado_d         = E_LANZAR;
                    lanzar_d         = 1'b1;
                    lanzar_idx_d     = libre_idx;
                    lanzar_columna_d = col_elegida;
                    columna_prev_d   = col_elegida;
                end else begin
                    // Spawn stays pending until a slot frees up.
                    todos_d = 1'b1;
                end
            end
            E_LANZAR: begin
                estado_d = bus.habilitar_cubos ? E_CUENTA : E_REPOSO;
                if (total_q != 8'hFF) begin
                    total_d = total_q + 8'd1;
                end
                if (cuenta_nivel_q == ULTIMO_NIVEL) begin
                    cuenta_nivel_d = 8'd0;
                    intervalo_d    = intervalo_reducido;
                    contador_d     = intervalo_reducido;
                    if (nivel_q != 4'hF) begin
                        nivel_d = nivel_q + 4'd1;
                    end
                end else begin
                    cuenta_nivel_d = cuenta_nivel_q + 8'd1;
                    contador_d     = intervalo_q;
                end
            end
            default: estado_d = E_REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q         <= E_REPOSO;
            contador_q       <= 8'd0;
            intervalo_q      <= INTERVALO_INI;
            cuenta_nivel_q   <= 8'd0;
            columna_prev_q   <= '0;
            lfsr_q           <= SEMILLA;
            lanzar_q         <= 1'b0;
            lanzar_idx_q     <= '0;
            lanzar_columna_q <= '0;
            nivel_q          <= 4'd0;
            total_q          <= 8'd0;
            todos_q          <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            contador_q       <= contador_d;
            intervalo_q      <= intervalo_d;
            cuenta_nivel_q   <= cuenta_nivel_d;
            columna_prev_q   <= columna_prev_d;
            lfsr_q           <= lfsr_d;
            lanzar_q         <= lanzar_d;
            lanzar_idx_q     <= lanzar_idx_d;
            lanzar_columna_q <= lanzar_columna_d;
            nivel_q          <= nivel_d;
            total_q          <= total_d;
            todos_q          <= todos_d;
        end
    end

    assign bus.lanzar         = lanzar_q;
    assign bus.lanzar_idx     = lanzar_idx_q;
    assign bus.lanzar_columna = lanzar_columna_q;
    assign bus.nivel          = nivel_q;
    assign bus.total_lanzados = total_q;
    assign bus.todos_ocupados = todos_q;
endmodule

// File: tb/tb_planificador_cubos.sv
// tb/tb_planificador_cubos.sv - directed scoreboard bench for the spawn scheduler
module tb_planificador_cubos;
    typedef struct {
        int         cyc;
        logic [1:0] idx;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic [2:0] col;
        logic [7:0] lfsr;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    planificador_cubos_if #(.NUM_CUBOS(4)) bus ();
    planificador_cubos #(.NUM_CUBOS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int rd = 0;
    int n_sp = 0;
    logic [2:0] col_prev_m = 3'd0;
    logic [2:0] last_col = 3'd0;
    bit have_last = 1'b0;

    logic [7:0] m_lfsr, m_prev;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, m_prev holds the value the DUT decided on.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    always @(negedge clk) begin
        obs_t o;
        if (bus.lanzar === 1'b1) begin
            o.cyc  = cyc;
            o.idx  = bus.lanzar_idx;
            o.col  = bus.lanzar_columna;
            o.lfsr = m_prev;
            obs_q.push_back(o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int gap_for(input int n);
        int g;
        g = 60 - 5 * (n / 8);
        return (g < 15) ? 15 : g;
    endfunction

    task automatic drain();
        obs_t o;
        exp_t e;
        logic [2:0] c;
        while (rd < obs_q.size()) begin
            o = obs_q[rd];
            rd++;
            chk("lanzar_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("lanzar_cycle", 32'(o.cyc), 32'(e.cyc));
                chk("lanzar_idx", 32'(o.idx), 32'(e.idx));
            end
            c = o.lfsr[2:0];
            if (c == col_prev_m) c = c + 3'd1;
            chk("lanzar_columna", 32'(o.col), 32'(c));
            if (have_last) chk("columna_no_repeat", 32'(o.col != last_col), 32'd1);
            col_prev_m = c;
            last_col   = o.col;
            have_last  = 1'b1;
        end
    endtask

    task automatic check_pending();
        chk("lanzar_missing", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_counts();
        chk("total_lanzados", 32'(bus.total_lanzados), 32'((n_sp > 255) ? 255 : n_sp));
        chk("nivel", 32'(bus.nivel), 32'((n_sp / 8 > 15) ? 15 : n_sp / 8));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_frame = 1'b1;
            @(negedge clk);
        end
        bus.tick_frame = 1'b0;
    endtask

    task automatic spawn(input int gap, input logic [1:0] idx);
        exp_t e;
        ticks(gap);
        e.cyc = cyc + 1;
        e.idx = idx;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        drain();
        check_pending();
        n_sp++;
        check_counts();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_lanzar"}, 32'(bus.lanzar), 32'd0);
        chk({tag, "_idx"}, 32'(bus.lanzar_idx), 32'd0);
        chk({tag, "_columna"}, 32'(bus.lanzar_columna), 32'd0);
        chk({tag, "_nivel"}, 32'(bus.nivel), 32'd0);
        chk({tag, "_total"}, 32'(bus.total_lanzados), 32'd0);
        chk({tag, "_todos"}, 32'(bus.todos_ocupados), 32'd0);
    endtask

    initial begin
        exp_t e;
        reset               = 1'b0;
        bus.habilitar_cubos = 1'b0;
        bus.tick_frame      = 1'b0;
        bus.cubo_activo     = 4'b0000;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        // First game: basic spawn, then slot arbitration.
        bus.habilitar_cubos = 1'b1;
        @(negedge clk);
        spawn(60, 2'd0);
        bus.cubo_activo = 4'b1011;
        spawn(gap_for(n_sp), 2'd2);

        bus.cubo_activo = 4'b1111;
        ticks(gap_for(n_sp));
        ticks(100);
        drain();
        chk("todos_ocupados_set", 32'(bus.todos_ocupados), 32'd1);
        chk("no_lanzar_when_full", 32'(bus.lanzar), 32'd0);
        bus.cubo_activo = 4'b0111;
        e.cyc = cyc + 1;
        e.idx = 2'd3;
        exp_q.push_back(e);
        @(negedge clk);
        chk("lanzar_after_free", 32'(bus.lanzar), 32'd1);
        chk("todos_ocupados_clear", 32'(bus.todos_ocupados), 32'd0);
        @(negedge clk);
        drain();
        check_pending();
        n_sp++;
        check_counts();

        // Level progression, interval floor, saturation and column no-repeat.
        bus.cubo_activo = 4'b0000;
        while (n_sp < 300) spawn(gap_for(n_sp), 2'd0);

        // Abort in the middle of counting.
        ticks(5);
        bus.habilitar_cubos = 1'b0;
        @(negedge clk);
        ticks(100);
        drain();
        chk("abort_nivel_held", 32'(bus.nivel), 32'd15);
        chk("abort_total_held", 32'(bus.total_lanzados), 32'd255);
        chk("abort_todos", 32'(bus.todos_ocupados), 32'd0);

        bus.habilitar_cubos = 1'b1;
        @(negedge clk);
        n_sp = 0;
        check_counts();
        spawn(60, 2'd0);

        // Abort on the E_ELEGIR cycle: abort wins over the spawn.
        ticks(gap_for(n_sp));
        bus.habilitar_cubos = 1'b0;
        repeat (6) @(negedge clk);
        drain();
        check_counts();

        bus.habilitar_cubos = 1'b1;
        @(negedge clk);
        n_sp = 0;
        check_counts();
        spawn(60, 2'd0);

        // Asynchronous reset while lanzar is high.
        ticks(gap_for(n_sp));
        e.cyc = cyc + 1;
        e.idx = 2'd0;
        exp_q.push_back(e);
        @(negedge clk);
        chk("lanzar_before_reset", 32'(bus.lanzar), 32'd1);
        #2 reset = 1'b0;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        drain();
        check_pending();
        col_prev_m = 3'd0;
        have_last  = 1'b0;
        n_sp       = 0;
        ticks(3);
        reset = 1'b1;
        @(negedge clk);
        drain();
        spawn(60, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
